// File: rtl/mem_image_loader.sv
// Byte-stream program loader: reads a 4-byte little-endian length header, packs the
// payload into little-endian 32-bit words and writes them upward from BASE_ADDR.
module mem_image_loader #(
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int unsigned LOAD_SIZE_IN_BYTE = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_width,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] bytes_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [29:0] word_idx_q, word_idx_d;
    logic [31:0] bytes_q, bytes_d;

    logic        hs;
    logic [31:0] len_full;
    logic [31:0] bytes_inc;

    assign hs        = in_valid && in_ready;
    assign len_full  = {in_data, len_q[23:0]};
    assign bytes_inc = bytes_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            hdr_cnt_q  <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            bytes_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            hdr_cnt_q  <= hdr_cnt_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            bytes_q    <= bytes_d;
        end
    end

    // abort is checked first so a byte handshaking in the same cycle leaves no trace
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        hdr_cnt_d  = hdr_cnt_q;
        lane_d     = lane_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        bytes_d    = bytes_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_d    = S_LEN;
                        len_d      = '0;
                        hdr_cnt_d  = '0;
                        lane_d     = '0;
                        word_d     = '0;
                        word_idx_d = '0;
                        bytes_d    = '0;
                    end
                end
                S_LEN: begin
                    if (hs) begin
                        len_d[{hdr_cnt_q, 3'b000} +: 8] = in_data;
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                        if (hdr_cnt_q == 2'd3) begin
                            if (len_full == 32'd0)
                                state_d = S_DONE;
                            else if (len_full > 32'(LOAD_SIZE_IN_BYTE))
                                state_d = S_ERROR;
                            else
                                state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        word_d[{lane_q, 3'b000} +: 8] = in_data;
                        bytes_d = bytes_inc;
                        lane_d  = lane_q + 2'd1;
                        if (lane_q == 2'd3 || bytes_inc == len_q)
                            state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_idx_d = word_idx_q + 30'd1;
                    word_d     = '0;
                    lane_d     = '0;
                    state_d    = (bytes_q == len_q) ? S_DONE : S_DATA;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Write-port outputs decode straight from state so reset drops the strobe at once
    always_comb begin
        in_ready         = (state_q == S_LEN) || (state_q == S_DATA);
        mem_write_enable = (state_q == S_WRITE);
        mem_addr         = '0;
        mem_write_width  = 4'd0;
        mem_write_data   = '0;
        if (state_q == S_WRITE) begin
            mem_addr        = BASE_ADDR + {word_idx_q, 2'b00};
            mem_write_width = 4'd4;
            mem_write_data  = word_q;
        end
        busy         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
        done         = (state_q == S_DONE);
        error        = (state_q == S_ERROR);
        bytes_loaded = bytes_q;
    end

endmodule
